// File: rtl/wired_cdb_sched_pkg.sv
// Shared CDB definitions: lane count, default ROB id width and the write-back request record.
package wired_cdb_sched_pkg;

  localparam int _WIRED_PARAM_ROB_LEN = 6;
  localparam int _WIRED_PARAM_DATA_W  = 32;
  localparam int _WIRED_CDB_LANES     = 2;

  typedef struct packed {
    logic [_WIRED_PARAM_ROB_LEN-1:0] wid;
    logic [_WIRED_PARAM_DATA_W-1:0]  wdata;
  } cdb_req_t;

endpackage

// File: rtl/wired_cdb_port_fifo.sv
// Per-producer result buffer; presents either its head or, when empty, the incoming request.
module wired_cdb_port_fifo
  import wired_cdb_sched_pkg::*;
#(
  parameter int ROB_LEN    = _WIRED_PARAM_ROB_LEN,
  parameter int DATA_W     = _WIRED_PARAM_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_valid_i,
  input  logic [ROB_LEN-1:0] push_wid_i,
  input  logic [DATA_W-1:0]  push_wdata_i,
  input  logic               pop_i,
  output logic               ready_o,
  output logic               cand_valid_o,
  output logic [ROB_LEN-1:0] cand_wid_o,
  output logic [DATA_W-1:0]  cand_wdata_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ROB_LEN-1:0] wid;
    logic [DATA_W-1:0]  wdata;
  } req_t;

  req_t          mem [FIFO_DEPTH];
  req_t          in_req;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          empty, xfer, pop_head, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_req       = '{wid: push_wid_i, wdata: push_wdata_i};
  assign ready_o      = (count != CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign xfer         = push_valid_i && ready_o;
  assign cand_valid_o = empty ? xfer : 1'b1;
  assign cand_wid_o   = empty ? in_req.wid   : mem[rd_ptr].wid;
  assign cand_wdata_o = empty ? in_req.wdata : mem[rd_ptr].wdata;
  assign pop_head     = pop_i && !empty;
  // A bypass-granted request never lands in storage.
  assign push         = xfer && !(pop_i && empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop_head) rd_ptr <= ptr_inc(rd_ptr);
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (push && !pop_head)      count <= count + 1'b1;
      else if (pop_head && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i) mem[wr_ptr] <= in_req;
  end

endmodule

// File: rtl/wired_cdb_sched.sv
// Two-lane CDB write-back scheduler: per-port buffers, per-lane round-robin, registered broadcast.
module wired_cdb_sched
  import wired_cdb_sched_pkg::*;
#(
  parameter int PORT_CNT   = 3,
  parameter int ROB_LEN    = _WIRED_PARAM_ROB_LEN,
  parameter int DATA_W     = _WIRED_PARAM_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush_i,
  input  logic [PORT_CNT-1:0]                      req_valid_i,
  output logic [PORT_CNT-1:0]                      req_ready_o,
  input  logic [PORT_CNT-1:0][ROB_LEN-1:0]         req_wid_i,
  input  logic [PORT_CNT-1:0][DATA_W-1:0]          req_wdata_i,
  output logic [_WIRED_CDB_LANES-1:0]              cdb_valid_o,
  output logic [_WIRED_CDB_LANES-1:0][ROB_LEN-1:0] cdb_wid_o,
  output logic [_WIRED_CDB_LANES-1:0][DATA_W-1:0]  cdb_wdata_o
);

  localparam int IW = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

  logic [PORT_CNT-1:0]                 cand_vld_p0;
  logic [PORT_CNT-1:0][ROB_LEN-1:0]    cand_wid_p0;
  logic [PORT_CNT-1:0][DATA_W-1:0]     cand_wdata_p0;
  logic [PORT_CNT-1:0]                 consume_p0;
  logic [_WIRED_CDB_LANES-1:0]         gnt_vld_p0;
  logic [_WIRED_CDB_LANES-1:0][IW-1:0] gnt_idx_p0;
  logic [_WIRED_CDB_LANES-1:0][IW-1:0] rr_ptr;

  function automatic logic [IW-1:0] rr_inc(input logic [IW-1:0] k);
    return (k == IW'(PORT_CNT - 1)) ? '0 : k + 1'b1;
  endfunction

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_port
    wired_cdb_port_fifo #(
      .ROB_LEN   (ROB_LEN),
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .push_valid_i(req_valid_i[p]),
      .push_wid_i  (req_wid_i[p]),
      .push_wdata_i(req_wdata_i[p]),
      .pop_i       (consume_p0[p]),
      .ready_o     (req_ready_o[p]),
      .cand_valid_o(cand_vld_p0[p]),
      .cand_wid_o  (cand_wid_p0[p]),
      .cand_wdata_o(cand_wdata_p0[p])
    );
  end

  // Stage p0: per-lane round-robin over the port candidates
  always_comb begin
    int j;
    gnt_vld_p0 = '0;
    gnt_idx_p0 = '0;
    consume_p0 = '0;
    for (int l = 0; l < _WIRED_CDB_LANES; l++) begin
      for (int i = 0; i < PORT_CNT; i++) begin
        j = int'(rr_ptr[l]) + i;
        if (j >= PORT_CNT) j = j - PORT_CNT;
        if (!gnt_vld_p0[l] && cand_vld_p0[j] && (cand_wid_p0[j][0] == l[0])) begin
          gnt_vld_p0[l] = 1'b1;
          gnt_idx_p0[l] = IW'(j);
        end
      end
      if (gnt_vld_p0[l]) consume_p0[gnt_idx_p0[l]] = 1'b1;
    end
  end

  // Stage p1: registered CDB broadcast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_o <= '0;
      cdb_wid_o   <= '0;
      cdb_wdata_o <= '0;
      rr_ptr      <= '0;
    end else if (flush_i) begin
      cdb_valid_o <= '0;
    end else begin
      for (int l = 0; l < _WIRED_CDB_LANES; l++) begin
        cdb_valid_o[l] <= gnt_vld_p0[l];
        if (gnt_vld_p0[l]) begin
          cdb_wid_o[l]   <= cand_wid_p0[gnt_idx_p0[l]];
          cdb_wdata_o[l] <= cand_wdata_p0[gnt_idx_p0[l]];
          rr_ptr[l]      <= rr_inc(gnt_idx_p0[l]);
        end
      end
    end
  end

endmodule

// File: tb/tb_wired_cdb_sched.sv
// Randomised and directed bench for wired_cdb_sched against a queue-based reference model.
module tb_wired_cdb_sched;
  import wired_cdb_sched_pkg::*;

  localparam int N     = 3;
  localparam int RL    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic                   clk   = 1'b0;
  logic                   rst   = 1'b1;
  logic                   flush = 1'b0;
  logic [N-1:0]           valid = '0;
  logic [N-1:0]           ready;
  logic [N-1:0][RL-1:0]   wid   = '0;
  logic [N-1:0][DW-1:0]   data  = '0;
  logic [1:0]             cdb_valid;
  logic [1:0][RL-1:0]     cdb_wid;
  logic [1:0][DW-1:0]     cdb_data;

  int tests = 0;
  int fails = 0;

  cdb_req_t           q [N][$];
  int                 rr [2];
  logic [1:0]         e_vld;
  logic [1:0][RL-1:0] e_wid;
  logic [1:0][DW-1:0] e_data;

  wired_cdb_sched #(.PORT_CNT(N), .ROB_LEN(RL), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_wid_i  (wid),
    .req_wdata_i(data),
    .cdb_valid_o(cdb_valid),
    .cdb_wid_o  (cdb_wid),
    .cdb_wdata_o(cdb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = (q[p].size() != DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) q[p].delete();
    rr[0] = 0;
    rr[1] = 0;
    e_vld  = '0;
    e_wid  = '0;
    e_data = '0;
  endtask

  // One clock of the scheduling rules, using the inputs currently driven.
  task automatic model_step();
    cdb_req_t cand [N];
    bit cv [N], head [N], xfer [N], gnt [N];
    cdb_req_t inc;
    if (flush) begin
      for (int p = 0; p < N; p++) q[p].delete();
      e_vld = '0;
      return;
    end
    for (int p = 0; p < N; p++) begin
      xfer[p] = valid[p] && (q[p].size() < DEPTH);
      gnt[p]  = 0;
      if (q[p].size() > 0) begin
        cand[p] = q[p][0];
        cv[p]   = 1;
        head[p] = 1;
      end else begin
        cand[p].wid   = wid[p];
        cand[p].wdata = data[p];
        cv[p]   = xfer[p];
        head[p] = 0;
      end
    end
    for (int l = 0; l < 2; l++) begin
      int win;
      win = -1;
      for (int i = 0; i < N; i++) begin
        int p;
        p = (rr[l] + i) % N;
        if (win < 0 && cv[p] && cand[p].wid[0] == l[0]) win = p;
      end
      if (win >= 0) begin
        e_vld[l]  = 1'b1;
        e_wid[l]  = cand[win].wid;
        e_data[l] = cand[win].wdata;
        rr[l]     = (win + 1) % N;
        gnt[win]  = 1;
      end else begin
        e_vld[l] = 1'b0;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (gnt[p] && head[p]) void'(q[p].pop_front());
      if (xfer[p] && !(gnt[p] && !head[p])) begin
        inc.wid   = wid[p];
        inc.wdata = data[p];
        q[p].push_back(inc);
      end
    end
  endtask

  task automatic compare();
    check("cdb_valid", 64'(cdb_valid), 64'(e_vld));
    check("cdb_wid",   64'(cdb_wid),   64'(e_wid));
    check("cdb_wdata", 64'(cdb_data),  64'(e_data));
    check("req_ready", 64'(ready),     64'(exp_ready()));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    valid = '0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_wid",   64'(cdb_wid),   64'(0));
    check("rst_wdata", 64'(cdb_data),  64'(0));
    check("rst_ready", 64'(ready),     64'(3'b111));
    rst = 1'b0;
    idle(2);

    // Single even-id bypass on lane 0
    valid = 3'b001; wid[0] = 6'h04; data[0] = 32'hDEADBEEF;
    step();
    check("t1_valid", 64'(cdb_valid),  64'(2'b01));
    check("t1_wid",   64'(cdb_wid[0]), 64'(6'h04));
    check("t1_data",  64'(cdb_data[0]), 64'(32'hDEADBEEF));
    check("t1_ready", 64'(ready),      64'(3'b111));
    idle(1);

    // Both lanes in one cycle
    valid = 3'b011; wid[0] = 6'h02; wid[1] = 6'h03;
    data[0] = 32'h1111_0002; data[1] = 32'h2222_0003;
    step();
    check("t2_valid", 64'(cdb_valid), 64'(2'b11));
    check("t2_wid1",  64'(cdb_wid[1]), 64'(6'h03));
    idle(1);

    // Three producers contending for lane 0
    valid = 3'b111; wid[0] = 6'h10; wid[1] = 6'h12; wid[2] = 6'h14;
    for (int i = 0; i < 6; i++) begin
      data[0] = 32'hA000_0000 + i; data[1] = 32'hB000_0000 + i; data[2] = 32'hC000_0000 + i;
      step();
    end
    idle(7);

    // Port 0 streams lane 0 while port 1 queues two results
    for (int i = 0; i < 4; i++) begin
      valid[0] = 1'b1; wid[0] = 6'h20 + 6'(2 * i); data[0] = 32'h5000_0000 + i;
      valid[1] = (i < 2); wid[1] = (i == 0) ? 6'h06 : 6'h08; data[1] = 32'h6000_0000 + i;
      valid[2] = 1'b0;
      step();
    end
    idle(4);

    // Flush with buffered entries and a same-cycle request
    valid = 3'b111; wid[0] = 6'h2A; wid[1] = 6'h2C; wid[2] = 6'h2E;
    for (int i = 0; i < 3; i++) begin
      data = {32'h7000_0000 + i, 32'h7100_0000 + i, 32'h7200_0000 + i};
      step();
    end
    flush = 1'b1; valid = 3'b100; wid[2] = 6'h3E; data[2] = 32'h0BAD_0BAD;
    step();
    check("t5_valid", 64'(cdb_valid), 64'(0));
    check("t5_ready", 64'(ready),     64'(3'b111));
    idle(4);

    // Asynchronous reset in the middle of a burst
    valid = 3'b111; wid[0] = 6'h01; wid[1] = 6'h18; wid[2] = 6'h1B;
    data = {32'h8000_0002, 32'h8000_0001, 32'h8000_0000};
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", 64'(cdb_valid), 64'(0));
    check("t6_wid",   64'(cdb_wid),   64'(0));
    check("t6_ready", 64'(ready),     64'(3'b111));
    model_reset();
    valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    valid = 3'b011; wid[0] = 6'h30; wid[1] = 6'h32; data[0] = 32'h9000_0000; data[1] = 32'h9000_0001;
    step();
    check("t6_first_wid", 64'(cdb_wid[0]), 64'(6'h30));
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      valid = N'($urandom);
      for (int p = 0; p < N; p++) begin
        wid[p]  = RL'($urandom);
        data[p] = $urandom;
      end
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wired_cdb_sched.md
Name: wired_cdb_sched

Overview:
Schedules result write-backs from several functional-unit issue queues (ALU lanes, LSU, MDU) onto the two common-data-bus lanes.
- Lane is selected by ROB id bit 0: even ids on lane 0, odd ids on lane 1.
- Each requester has a small per-port FIFO with empty-bypass, so a busy lane stalls only that producer, not the issue queue's pipeline.
- Each lane has a round-robin arbiter, and CDB outputs are registered.
- Sits between the IQ `cdb_o` outputs and the ROB / IQ wake-up / P-stage forwarding consumers.

Parameters:
PORT_CNT, 3, number of requesting producers (1..8)
ROB_LEN, 6, ROB id width in bits; bit 0 selects the lane
DATA_W, 32, result data width
FIFO_DEPTH, 2, entries per port buffer (power of two, >=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
flush_i  input  1  pipeline flush from commit; discards all buffered results
req_valid_i  input  PORT_CNT  producer result valid
req_ready_o  output  PORT_CNT  producer may hand over a result this cycle
req_wid_i  input  PORT_CNT x ROB_LEN  destination ROB id per port
req_wdata_i  input  PORT_CNT x DATA_W  result data per port
cdb_valid_o  output  2  lane broadcast valid
cdb_wid_o  output  2 x ROB_LEN  lane ROB id; bit 0 always equals the lane index
cdb_wdata_o  output  2 x DATA_W  lane data

Behaviour:
- Reset (async, `rst`=1):
  - FIFO counts and read/write pointers go to 0.
  - Both round-robin pointers go to 0.
  - `cdb_valid_o`=0, `cdb_wid_o`=0, `cdb_wdata_o`=0.
  - `req_ready_o` = all ones, since every count is 0.
  - Reset mid-operation drops all buffered results silently.
- Handshake: a transfer happens on port p when `req_valid_i[p]` && `req_ready_o[p]`.
  - `req_ready_o[p]` = (count[p] != FIFO_DEPTH). It is taken from registered state only, with no combinational path from any valid.
- Candidate per port:
  - If count[p] > 0, the candidate is the FIFO head.
  - If count[p] = 0, the candidate is the incoming request when it transfers (empty bypass).
  - Candidate lane = candidate wid[0].
- Lane arbitration, lane L, evaluated each cycle:
  - Search ports starting at rr_ptr[L] and wrapping modulo PORT_CNT.
  - The first valid candidate with lane L wins.
  - Each port has one candidate, so it receives at most one grant per cycle.
- Grant effects, port k granted on lane L:
  - At the next edge, `cdb_valid_o[L]`<=1, `cdb_wid_o[L]`<=candidate wid, `cdb_wdata_o[L]`<=candidate data.
  - rr_ptr[L] <= (k+1) mod PORT_CNT.
  - If the grant came from the bypass, nothing is enqueued.
  - If it came from the head, the head pops.
- No grant on lane L: `cdb_valid_o[L]`<=0, `cdb_wid_o[L]`/`cdb_wdata_o[L]` hold their values, rr_ptr[L] unchanged.
- Enqueue: a transferred request that was not bypass-granted is written at the tail.
  - Pop and push in the same cycle keep the count unchanged.
  - A push when count = FIFO_DEPTH cannot occur, because ready is low.
- Latency: from the accepting edge to visible `cdb_valid_o` is 1 cycle with an empty FIFO and a won lane; otherwise it is 1 + cycles waited.
- Ordering: per-port FIFO order is preserved. Results from the same port on different lanes may still only issue head-first; head-of-line blocking is accepted.
- Flush (`flush_i`=1 at an edge):
  - All FIFO counts go to 0.
  - `cdb_valid_o` <= 0 for both lanes.
  - Transfers in that cycle are discarded.
  - rr pointers hold.
  - Flush has priority over grant and enqueue.
- Pointer wrap: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- No combinational path from any input to any CDB output.

Decomposition:
- Shared package (alongside `pipeline_cdb_t` in the wired defines):
  - `cdb_req_t` {wid, wdata}
  - constant `_WIRED_CDB_LANES` = 2
  - reuse `_WIRED_PARAM_ROB_LEN` as the ROB_LEN default source
- One sub-module, `wired_cdb_port_fifo`:
  - PORT_CNT instances.
  - Each instance provides depth-N storage, count, ready, head, and the empty-bypass candidate mux.
  - Each instance takes a pop/consume input.
- Arbiters and output registers live in the top module.

Test Plan:
1. Reset release, idle, then port0 sends wid=0x04, data=0xDEADBEEF -> next cycle `cdb_valid_o`=2'b01, `cdb_wid_o[0]`=0x04, `cdb_wdata_o[0]`=0xDEADBEEF; `req_ready_o`=3'b111 throughout.
2. Same cycle: port0 wid=0x02, port1 wid=0x03 -> one cycle later both lanes valid, lane0 wid=0x02, lane1 wid=0x03; no FIFO occupancy.
3. Ports 0,1,2 all send even ids (0x10, 0x12, 0x14) every cycle with rr_ptr=0 -> lane0 order 0x10, 0x12, 0x14, then port0's next; lane1 stays idle; ports 1 and 2 reach ready=0 after 2 buffered entries.
4. Fill port1 FIFO (2 entries: 0x06, 0x08) while port0 holds lane0, then drop port0 -> 0x06 then 0x08 on consecutive cycles, ready[1] returns to 1 the cycle after the first pop.
5. With 2 entries buffered on port2, assert `flush_i` together with a new valid on port2 -> next cycle `cdb_valid_o`=0, count=0, `req_ready_o[2]`=1, and the flushed data never appears.
6. Assert `rst` asynchronously mid-burst, between clock edges -> `cdb_valid_o` goes 0 immediately without waiting for an edge; after release the first new request appears with latency 1 and rr starts at port 0.
